// File: rtl/imem_bank.sv
// IF-stage instruction memory: 1-cycle fetch with stall/flush, store-to-imem
// with write-first forwarding, and an in-band byte-stream boot loader.
module imem_bank #(
   parameter int DATA_W    = 32,
   parameter int PC_W      = 25,
   parameter int AW        = 14,
   parameter int DADDR_W   = 30,
   parameter int TAG_LSB   = 25,
   parameter int LOAD_BASE = 0,
   parameter int BOOT_LOAD = 0,
   parameter logic [DATA_W-1:0] NOP = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [PC_W-1:0]     pc,
   input  logic [PC_W-1:0]     npc,
   input  logic                npc_enn,
   input  logic                n_stall,
   input  logic                flush,
   input  logic [DADDR_W-1:0]  daddr,
   input  logic [DATA_W-1:0]   dec_op2,
   input  logic                dec_mwe,
   input  logic                ld_start,
   input  logic                ld_valid,
   input  logic [7:0]          ld_byte,
   input  logic                ld_last,
   output logic                ld_ready,
   output logic                busy,
   output logic [DATA_W-1:0]   inst,
   output logic [PC_W-1:0]     if_pc,
   output logic                inst_valid
);

   localparam int DEPTH = 1 << AW;
   localparam int LANES = DATA_W / 8;
   localparam int BW    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [AW-1:0] BASE      = AW'(LOAD_BASE);
   localparam logic [BW-1:0] LAST_LANE = BW'(LANES - 1);

   typedef enum logic {S_RUN, S_LOAD} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] inst_q, inst_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [DATA_W-1:0] word_ld, wdata;
   logic [PC_W-1:0]   if_pc_q, if_pc_d, fetch_a;
   logic              valid_q, valid_d;
   logic [AW-1:0]     wptr_q, wptr_d, widx, fidx, sidx;
   logic [BW-1:0]     bcnt_q, bcnt_d;
   logic              st_hit, ld_fire, ld_wr, we;
   logic              unused_daddr;

   assign unused_daddr = ^daddr;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= (BOOT_LOAD != 0) ? S_LOAD : S_RUN;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RUN:   if (ld_start) state_d = S_LOAD;
         S_LOAD:  if (ld_valid && ld_last) state_d = S_RUN;
         default: state_d = S_RUN;
      endcase
   end

   // Moore outputs
   always_comb begin
      ld_ready = (state_q == S_LOAD);
      busy     = (state_q == S_LOAD);
   end

   assign fetch_a = npc_enn ? npc : pc;
   assign fidx    = fetch_a[AW-1:0];
   assign sidx    = daddr[AW-1:0];

   always_comb begin
      st_hit  = (state_q == S_RUN) && n_stall && dec_mwe
                && (&daddr[DADDR_W-1:TAG_LSB]);
      ld_fire = (state_q == S_LOAD) && ld_valid;
      // Lanes above bcnt are always zero in shreg, so a short last word pads with 0.
      word_ld = shreg_q | (DATA_W'(ld_byte) << {bcnt_q, 3'b000});
      ld_wr   = ld_fire && ((bcnt_q == LAST_LANE) || ld_last);
      we      = st_hit || ld_wr;
      widx    = st_hit ? sidx : wptr_q;
      wdata   = st_hit ? dec_op2 : word_ld;
   end

   always_comb begin
      shreg_d = shreg_q;
      bcnt_d  = bcnt_q;
      wptr_d  = wptr_q;
      if (ld_fire) begin
         if (ld_wr) begin
            shreg_d = '0;
            bcnt_d  = '0;
            wptr_d  = ld_last ? BASE : wptr_q + 1'b1;
         end else begin
            shreg_d = word_ld;
            bcnt_d  = bcnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      inst_d  = inst_q;
      if_pc_d = if_pc_q;
      valid_d = valid_q;
      if (state_q == S_LOAD) begin
         inst_d  = NOP;
         valid_d = 1'b0;
      end else if (n_stall) begin
         if_pc_d = fetch_a;
         valid_d = ~flush;
         if (flush)                       inst_d = NOP;
         else if (st_hit && sidx == fidx) inst_d = dec_op2;
         else                             inst_d = mem[fidx];
      end else if (flush) begin
         inst_d  = NOP;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_q  <= NOP;
         if_pc_q <= '0;
         valid_q <= 1'b0;
         wptr_q  <= BASE;
         bcnt_q  <= '0;
         shreg_q <= '0;
      end else begin
         inst_q  <= inst_d;
         if_pc_q <= if_pc_d;
         valid_q <= valid_d;
         wptr_q  <= wptr_d;
         bcnt_q  <= bcnt_d;
         shreg_q <= shreg_d;
      end
   end

   // Contents survive reset; no reset on the array.
   always_ff @(posedge clk) begin
      if (we) mem[widx] <= wdata;
   end

   assign inst       = inst_q;
   assign if_pc      = if_pc_q;
   assign inst_valid = valid_q;

endmodule

// File: tb/tb_imem_bank.sv
// Self-checking bench for imem_bank: small memory with the load base at the
// last word so loader wrap-around is exercised; random traffic vs. a model.
module tb_imem_bank;

   localparam int DEP = 64;
   localparam int LB  = DEP - 1;

   logic        clk = 1'b0;
   logic        rst;
   logic [24:0] pc, npc;
   logic        npc_enn, n_stall, flush;
   logic [29:0] daddr;
   logic [31:0] dec_op2;
   logic        dec_mwe, ld_start, ld_valid, ld_last;
   logic [7:0]  ld_byte;
   logic        ld_ready, busy, inst_valid;
   logic [31:0] inst;
   logic [24:0] if_pc;

   imem_bank #(
      .AW(6), .LOAD_BASE(LB), .BOOT_LOAD(1)
   ) dut (
      .clk(clk), .rst(rst), .pc(pc), .npc(npc), .npc_enn(npc_enn),
      .n_stall(n_stall), .flush(flush), .daddr(daddr), .dec_op2(dec_op2),
      .dec_mwe(dec_mwe), .ld_start(ld_start), .ld_valid(ld_valid),
      .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ld_ready),
      .busy(busy), .inst(inst), .if_pc(if_pc), .inst_valid(inst_valid)
   );

   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;

   // Behavioural model
   logic [31:0] mm [DEP];
   logic        ms;
   int          wp;
   logic [7:0]  bq [$];
   logic [31:0] exp_inst;
   logic [24:0] exp_pc;
   logic        exp_v, exp_busy;
   logic [31:0] imgw [DEP];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] expv);
      nchk++;
      if (act !== expv) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
      end
   endtask

   task automatic model_step();
      logic [24:0] a;
      logic [31:0] w;
      if (rst) begin
         ms = 1'b1;
         exp_inst = 0; exp_pc = 0; exp_v = 0;
         wp = LB;
         bq.delete();
      end else if (!ms) begin
         a = npc_enn ? npc : pc;
         if (n_stall) begin
            if (dec_mwe && daddr[29:25] == 5'h1f)
               mm[int'(daddr % 64)] = dec_op2;
            exp_pc   = a;
            exp_v    = !flush;
            exp_inst = flush ? 32'h0 : mm[int'(a % 64)];
         end else if (flush) begin
            exp_inst = 0;
            exp_v    = 0;
         end
         if (ld_start) ms = 1'b1;
      end else begin
         exp_inst = 0;
         exp_v    = 0;
         if (ld_valid) begin
            bq.push_back(ld_byte);
            if (bq.size() == 4 || ld_last) begin
               w = 0;
               foreach (bq[i]) w = w | (32'(bq[i]) << (8 * i));
               mm[wp] = w;
               wp = (wp + 1) % DEP;
               bq.delete();
               if (ld_last) begin
                  wp = LB;
                  ms = 1'b0;
               end
            end
         end
      end
      exp_busy = ms;
   endtask

   // Compare process: every cycle, 1 time unit after the active edge
   always @(posedge clk) begin
      #1;
      chk("inst", inst, exp_inst);
      chk("if_pc", 32'(if_pc), 32'(exp_pc));
      chk("inst_valid", 32'(inst_valid), 32'(exp_v));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("ld_ready", 32'(ld_ready), 32'(exp_busy));
   end

   task automatic cyc();
      model_step();
      @(posedge clk);
      #2;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      ld_valid = 1'b1;
      ld_byte  = b;
      ld_last  = last;
      pc       = 25'($urandom);
      dec_mwe  = 1'($urandom);
      daddr    = {5'h1f, 25'($urandom)};
      ld_start = 1'($urandom);
      cyc();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      if ($urandom_range(0, 3) == 0) cyc();
   endtask

   task automatic fetch(input logic [24:0] p);
      pc = p; npc_enn = 0; n_stall = 1; flush = 0;
      dec_mwe = 0; ld_start = 0; ld_valid = 0;
      cyc();
   endtask

   initial begin
      logic [7:0] d7 [7];
      rst = 1; pc = 0; npc = 0; npc_enn = 0; n_stall = 1; flush = 0;
      daddr = 0; dec_op2 = 0; dec_mwe = 0; ld_start = 0;
      ld_valid = 0; ld_byte = 0; ld_last = 0;
      cyc();
      cyc();
      chk("rst_busy", 32'(busy), 32'h1);
      chk("rst_inst", inst, 32'h0);
      chk("rst_if_pc", 32'(if_pc), 32'h0);
      chk("rst_valid", 32'(inst_valid), 32'h0);
      rst = 0;

      // Boot image fills every word, starting at the last index and wrapping
      foreach (imgw[i]) imgw[i] = $urandom;
      imgw[5] = 32'hDEADBEEF;
      for (int j = 0; j < DEP; j++)
         for (int k = 0; k < 4; k++)
            send_byte(8'(imgw[(LB + j) % DEP] >> (8 * k)),
                      (j == DEP - 1) && (k == 3));
      chk("boot_done_busy", 32'(busy), 32'h0);

      fetch(25'd5);
      chk("t1_inst", inst, 32'hDEADBEEF);
      chk("t1_if_pc", 32'(if_pc), 32'd5);
      chk("t1_valid", 32'(inst_valid), 32'h1);
      npc = 25'd9; npc_enn = 1;
      cyc();
      chk("t1_npc", 32'(if_pc), 32'd9);
      chk("t1_npc_inst", inst, imgw[9]);

      n_stall = 0;
      for (int i = 0; i < 3; i++) begin
         pc = 25'($urandom); npc = 25'($urandom);
         cyc();
         chk("t2_hold_pc", 32'(if_pc), 32'd9);
         chk("t2_hold_inst", inst, imgw[9]);
      end
      flush = 1;
      cyc();
      chk("t2_flush_inst", inst, 32'h0);
      chk("t2_flush_valid", 32'(inst_valid), 32'h0);
      chk("t2_flush_pc", 32'(if_pc), 32'd9);
      flush = 0;

      pc = 25'd7; npc_enn = 0; n_stall = 1;
      daddr = 30'h3E00_0007; dec_op2 = 32'h1234_5678; dec_mwe = 1;
      cyc();
      chk("t3_fwd", inst, 32'h1234_5678);
      daddr = 30'h1E00_0007; dec_op2 = 32'hCAFE_F00D;
      cyc();
      chk("t3_notag", inst, 32'h1234_5678);
      dec_mwe = 0;
      cyc();
      chk("t3_kept", inst, 32'h1234_5678);

      ld_start = 1;
      cyc();
      ld_start = 0;
      chk("t4_busy", 32'(busy), 32'h1);
      chk("t4_ready", 32'(ld_ready), 32'h1);
      d7 = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD};
      for (int i = 0; i < 7; i++) begin
         send_byte(d7[i], i == 6);
         if (i < 6) chk("t4_valid_low", 32'(inst_valid), 32'h0);
      end
      chk("t4_busy_drop", 32'(busy), 32'h0);
      fetch(25'd63);
      chk("t5_word_last", inst, 32'h1234_5678);
      fetch(25'd0);
      chk("t5_word_wrap", inst, 32'h00AD_BEEF);

      ld_start = 1;
      cyc();
      ld_start = 0;
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      rst = 1;
      #1;
      chk("t6_busy", 32'(busy), 32'h1);
      chk("t6_inst", inst, 32'h0);
      chk("t6_if_pc", 32'(if_pc), 32'h0);
      chk("t6_valid", 32'(inst_valid), 32'h0);
      cyc();
      rst = 0;
      send_byte(8'h11, 1);
      fetch(25'd63);
      chk("t6_no_partial", inst, 32'h0000_0011);
      fetch(25'd0);
      chk("t6_other_word", inst, 32'h00AD_BEEF);

      // Random traffic; loader driven whenever the model says LOAD
      for (int c = 0; c < 4000; c++) begin
         if (ms) begin
            ld_valid = 1'($urandom);
            ld_byte  = 8'($urandom);
            ld_last  = ld_valid && ($urandom_range(0, 11) == 0);
         end else begin
            ld_valid = 0;
            ld_last  = 0;
         end
         pc       = 25'($urandom);
         npc      = 25'($urandom);
         npc_enn  = 1'($urandom);
         n_stall  = ($urandom_range(0, 4) != 0);
         flush    = ($urandom_range(0, 7) == 0);
         dec_mwe  = 1'($urandom);
         dec_op2  = $urandom;
         daddr    = {($urandom_range(0, 1) == 1) ? 5'h1f : 5'($urandom),
                     25'($urandom)};
         if ($urandom_range(0, 3) == 0) daddr[5:0] = pc[5:0];
         ld_start = ($urandom_range(0, 199) == 0);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
